// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler: issues mult/div to the shared multdiv unit,
// holds the result until the write port is free, and stalls on hazards.
module multdiv_scheduler #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [31:0] issue_ir,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  fd_rs_a,
    input  logic [4:0]  fd_rs_b,
    input  logic        pipe_wb_en,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_result_rdy,
    output logic        issue_stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        WB
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);
    localparam logic [4:0] EXC_REG = 5'd30;

    state_t      state;
    logic        pend_div;
    logic [4:0]  pend_rd;
    logic        exc;
    logic [7:0]  count;

    logic        is_mult;
    logic        is_div;
    logic        is_md;
    logic [4:0]  ir_rd;
    logic [7:0]  count_next;
    logic        timeout_hit;
    logic [31:0] exc_code;
    logic [4:0]  eff_rd;
    logic        raw_hit;
    logic        unused_ir;

    assign unused_ir = ^{issue_ir[21:7], issue_ir[1:0]};

    assign is_mult = (issue_ir[31:27] == 5'd0) && (issue_ir[6:2] == 5'd6);
    assign is_div  = (issue_ir[31:27] == 5'd0) && (issue_ir[6:2] == 5'd7);
    assign is_md   = is_mult || is_div;
    assign ir_rd   = issue_ir[26:22];

    assign count_next  = (count == 8'hFF) ? count : count + 8'd1;
    assign timeout_hit = (count_next >= TMO);
    assign exc_code    = pend_div ? 32'd5 : 32'd4;

    // Sequencer: accept, pulse start, wait for result or timeout, write back
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            md_a     <= '0;
            md_b     <= '0;
            pend_div <= 1'b0;
            pend_rd  <= '0;
            exc      <= 1'b0;
            count    <= '0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue_valid && is_md) begin
                        md_a     <= issue_a;
                        md_b     <= issue_b;
                        pend_rd  <= ir_rd;
                        pend_div <= is_div;
                        exc      <= 1'b0;
                        count    <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    count <= count_next;
                    if (md_result_rdy) begin
                        exc     <= md_exception;
                        wb_reg  <= md_exception ? EXC_REG : pend_rd;
                        wb_data <= md_exception ? exc_code : md_result;
                        state   <= WB;
                    end else if (timeout_hit) begin
                        exc     <= 1'b1;
                        wb_reg  <= EXC_REG;
                        wb_data <= exc_code;
                        state   <= WB;
                    end
                end
                WB: begin
                    if (!pipe_wb_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state; the write yields to the pipeline
    always_comb begin
        busy         = (state != IDLE);
        md_ctrl_mult = (state == START) && !pend_div;
        md_ctrl_div  = (state == START) && pend_div;
        wb_en        = (state == WB) && !pipe_wb_en
                       && (exc || (pend_rd != 5'd0));
        eff_rd       = exc ? EXC_REG : pend_rd;
        raw_hit      = (eff_rd != 5'd0)
                       && ((fd_rs_a == eff_rd) || (fd_rs_b == eff_rd));
        issue_stall  = busy && ((issue_valid && is_md) || raw_hit);
    end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// tb_multdiv_scheduler: directed and random stimulus checked each cycle
// against a transaction-level model of the scheduler.
module tb_multdiv_scheduler;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_ir = '0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic [4:0]  fd_rs_a = '0;
    logic [4:0]  fd_rs_b = '0;
    logic        pipe_wb_en = 1'b0;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_result_rdy = 1'b0;
    logic        issue_stall;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    multdiv_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ir(issue_ir),
        .issue_a(issue_a), .issue_b(issue_b),
        .fd_rs_a(fd_rs_a), .fd_rs_b(fd_rs_b),
        .pipe_wb_en(pipe_wb_en),
        .md_a(md_a), .md_b(md_b),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_result(md_result), .md_exception(md_exception),
        .md_result_rdy(md_result_rdy),
        .issue_stall(issue_stall),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d",
                     name, act, exp, cycle);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd);
        return (32'(rd) << 22) | (32'(op) << 2);
    endfunction

    function automatic bit dec_md(input logic [31:0] ir);
        return (ir[31:27] == 0) && (ir[6:2] == 6 || ir[6:2] == 7);
    endfunction

    // Transaction model: one outstanding op, its age since START,
    // and whether its outcome has been decided.
    bit          m_live = 0;
    bit          m_done = 0;
    bit          m_exc = 0;
    bit          m_div = 0;
    bit          m_fresh = 1;
    int          m_age = 0;
    int          m_rd = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_res = '0;

    int          wr_count = 0;
    int          last_reg = -1;
    logic [31:0] last_data = '0;
    int          last_cycle = 0;
    int          mult_pulses = 0;
    int          div_pulses = 0;

    always @(negedge clock) begin
        bit          e_wb;
        bit          e_stall;
        int          eff;
        int          e_reg;
        logic [31:0] e_data;
        eff     = m_exc ? 30 : m_rd;
        e_wb    = m_live && m_done && !pipe_wb_en && (m_exc || m_rd != 0);
        e_stall = m_live && ((issue_valid && dec_md(issue_ir))
                  || (eff != 0 && (fd_rs_a == eff || fd_rs_b == eff)));
        e_reg   = m_exc ? 30 : m_rd;
        e_data  = m_exc ? (m_div ? 32'd5 : 32'd4) : m_res;
        check("busy", busy, m_live);
        check("ctrl_mult", md_ctrl_mult, m_live && m_age == 0 && !m_div);
        check("ctrl_div", md_ctrl_div, m_live && m_age == 0 && m_div);
        check("wb_en", wb_en, e_wb);
        check("issue_stall", issue_stall, e_stall);
        check("md_a", md_a, m_a);
        check("md_b", md_b, m_b);
        if (e_wb) begin
            check("wb_reg", 32'(wb_reg), 32'(e_reg));
            check("wb_data", wb_data, e_data);
        end
        if (m_fresh) begin
            check("rst_wb_reg", 32'(wb_reg), 0);
            check("rst_wb_data", wb_data, 0);
        end
        if (wb_en) begin
            wr_count++;
            last_reg   = int'(wb_reg);
            last_data  = wb_data;
            last_cycle = cycle;
        end
        if (md_ctrl_mult) mult_pulses++;
        if (md_ctrl_div) div_pulses++;

        if (!reset) begin
            m_live = 0; m_done = 0; m_exc = 0; m_div = 0; m_fresh = 1;
            m_age = 0; m_rd = 0; m_a = '0; m_b = '0; m_res = '0;
        end else if (!m_live) begin
            if (issue_valid && dec_md(issue_ir)) begin
                m_live = 1; m_done = 0; m_exc = 0; m_fresh = 0;
                m_age = 0; m_rd = int'(issue_ir[26:22]);
                m_div = (issue_ir[6:2] == 7);
                m_a = issue_a; m_b = issue_b;
            end
        end else if (m_done) begin
            if (!pipe_wb_en) m_live = 0;
        end else begin
            if (m_age >= 1) begin
                if (md_result_rdy) begin
                    m_done = 1; m_exc = md_exception; m_res = md_result;
                end else if (m_age == TIMEOUT) begin
                    m_done = 1; m_exc = 1;
                end
            end
            m_age++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int op, input int rd,
                         input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        issue_ir    = mk(op, rd);
        issue_a     = a;
        issue_b     = b;
    endtask

    initial begin
        int t0;
        int w0;
        int p0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_md_a", md_a, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_stall", issue_stall, 0);
        reset = 1'b1;

        // mult r5 = 6*7, result 17 cycles after START
        w0 = wr_count; p0 = mult_pulses; t0 = cycle;
        issue(6, 5, 6, 7);
        step();
        issue_valid = 1'b0;
        repeat (17) step();
        md_result_rdy = 1'b1; md_result = 42;
        step();
        md_result_rdy = 1'b0; md_result = 0;
        repeat (3) step();
        check("mult_count", wr_count, w0 + 1);
        check("mult_reg", last_reg, 5);
        check("mult_data", last_data, 42);
        check("mult_lat", last_cycle - t0, 19);
        check("mult_pulse", mult_pulses, p0 + 1);

        // div r4 by zero
        w0 = wr_count; p0 = div_pulses;
        issue(7, 4, 9, 0);
        step();
        issue_valid = 1'b0;
        repeat (3) step();
        md_result_rdy = 1'b1; md_exception = 1'b1; md_result = 32'hdead;
        step();
        md_result_rdy = 1'b0; md_exception = 1'b0;
        repeat (3) step();
        check("div0_count", wr_count, w0 + 1);
        check("div0_reg", last_reg, 30);
        check("div0_data", last_data, 5);
        check("div0_pulse", div_pulses, p0 + 1);

        // port conflict: pipeline holds the port for 3 WB cycles
        w0 = wr_count; t0 = cycle;
        issue(6, 7, 11, 12);
        step();
        issue_valid = 1'b0;
        repeat (2) step();
        md_result_rdy = 1'b1; md_result = 123;
        step();
        md_result_rdy = 1'b0;
        pipe_wb_en = 1'b1;
        repeat (3) step();
        check("port_held", wr_count, w0);
        pipe_wb_en = 1'b0;
        step();
        check("port_count", wr_count, w0 + 1);
        check("port_data", last_data, 123);
        check("port_lat", last_cycle - t0, 7);

        // RAW and structural hazards
        issue(6, 5, 2, 3);
        step();
        issue_valid = 1'b0;
        step();
        fd_rs_a = 5;
        #1 check("raw_5", issue_stall, 1);
        fd_rs_a = 0;
        #1 check("raw_0", issue_stall, 0);
        fd_rs_a = 6;
        #1 check("raw_6", issue_stall, 0);
        fd_rs_a = 0;
        step();
        issue(6, 8, 3, 4);
        #1 check("struct_busy", issue_stall, 1);
        step();
        md_result_rdy = 1'b1; md_result = 6;
        step();
        md_result_rdy = 1'b0;
        #1 check("struct_wb", issue_stall, 1);
        step();
        check("struct_idle", issue_stall, 0);
        step();
        issue_valid = 1'b0;
        check("struct_a", md_a, 3);
        repeat (3) step();
        md_result_rdy = 1'b1; md_result = 12;
        step();
        md_result_rdy = 1'b0;
        repeat (3) step();
        check("struct_reg", last_reg, 8);
        check("struct_data", last_data, 12);

        // rd = 0 is never written
        w0 = wr_count;
        issue(6, 0, 5, 5);
        step();
        issue_valid = 1'b0;
        repeat (2) step();
        md_result_rdy = 1'b1; md_result = 25;
        step();
        md_result_rdy = 1'b0;
        repeat (3) step();
        check("r0_nowrite", wr_count, w0);

        // timeout without any result
        w0 = wr_count; t0 = cycle;
        issue(6, 9, 1, 1);
        step();
        issue_valid = 1'b0;
        repeat (46) step();
        check("tmo_count", wr_count, w0 + 1);
        check("tmo_reg", last_reg, 30);
        check("tmo_data", last_data, 4);
        check("tmo_lat", last_cycle - t0, 42);

        // reset mid-BUSY, then a late result
        w0 = wr_count;
        issue(7, 3, 77, 88);
        step();
        issue_valid = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        step();
        check("rmid_busy", busy, 0);
        check("rmid_md_a", md_a, 0);
        check("rmid_md_b", md_b, 0);
        check("rmid_wb_data", wb_data, 0);
        reset = 1'b1;
        md_result_rdy = 1'b1; md_result = 99;
        step();
        md_result_rdy = 1'b0;
        repeat (3) step();
        check("rmid_nowrite", wr_count, w0);
        check("rmid_idle", busy, 0);

        // random traffic
        repeat (4000) begin
            int sel;
            sel = $urandom_range(0, 3);
            issue_valid = ($urandom_range(0, 2) == 0);
            case (sel)
                0: issue_ir = mk(6, $urandom_range(1, 31));
                1: issue_ir = mk(7, $urandom_range(1, 31));
                2: issue_ir = $urandom;
                default: issue_ir = mk($urandom_range(0, 31),
                                       $urandom_range(0, 31));
            endcase
            issue_a       = $urandom;
            issue_b       = $urandom;
            fd_rs_a       = 5'($urandom_range(0, 31));
            fd_rs_b       = 5'($urandom_range(0, 31));
            pipe_wb_en    = ($urandom_range(0, 2) == 0);
            md_result_rdy = ($urandom_range(0, 7) == 0);
            md_exception  = ($urandom_range(0, 3) == 0);
            md_result     = $urandom;
            reset         = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1'b1;
        issue_valid = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_scheduler.md
# multdiv_scheduler

Sequencing controller for the shared multi-cycle multiply/divide unit. It accepts `mult` and `div` instructions from the execute (DX) stage and launches the multdiv unit. It holds the finished result until the register-file write port is free, then commits it to the destination register, or to `r30` with a status code on exception. While an operation is outstanding it generates the pipeline stall for structural and RAW hazards.

## Interface
Parameters:
- TIMEOUT, 40, maximum number of cycles spent in BUSY before a forced exception (1..255)

Ports:
- clock  input  1  master clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising clock edge)
- issue_valid  input  1  DX stage holds a valid instruction this cycle
- issue_ir  input  32  DX instruction word
- issue_a, issue_b  input  32  bypassed DX operands A and B
- fd_rs_a, fd_rs_b  input  5  register indices being read by the decode stage
- pipe_wb_en  input  1  MW stage is writing the register file this cycle
- md_a, md_b  output  32  latched operands to the multdiv unit
- md_ctrl_mult, md_ctrl_div  output  1  one-cycle start pulses to the multdiv unit
- md_result  input  32  multdiv result
- md_exception  input  1  multdiv exception (overflow or divide by zero)
- md_result_rdy  input  1  multdiv result valid
- issue_stall  output  1  freeze the FD and DX stages
- wb_en  output  1  scheduler owns the register-file write port this cycle
- wb_reg  output  5  write register index
- wb_data  output  32  write data
- busy  output  1  state is not IDLE

## Operation
- **Instruction decode:**
  - `mult` = `issue_ir[31:27]==0` and `issue_ir[6:2]==6`.
  - `div` = `issue_ir[31:27]==0` and `issue_ir[6:2]==7`.
  - `rd` = `issue_ir[26:22]`.
  - All other instructions are ignored.
- **FSM states:** IDLE, START, BUSY, WB.
- **IDLE:**
  - On `issue_valid` with `mult` or `div`: latch `issue_a`/`issue_b` into `md_a`/`md_b`, and latch `rd` and the op into `pend_rd` and `pend_op`.
  - Clear the cycle counter and go to START.
- **START:**
  - Assert `md_ctrl_mult` or `md_ctrl_div` (per `pend_op`) for exactly this one cycle.
  - Go to BUSY.
- **BUSY:**
  - The counter increments each cycle.
  - On `md_result_rdy`: capture the result and exception flag, then go to WB.
  - If the counter reaches TIMEOUT with no `md_result_rdy`: capture exception = 1, then go to WB.
  - `md_result_rdy` seen in START is ignored.
- **WB:**
  - If `pipe_wb_en`=0: assert `wb_en` this cycle and go to IDLE.
  - Otherwise hold in WB; the pipeline has priority on the write port.
  - Write data when no exception: `wb_reg`=`pend_rd`, `wb_data`=result.
  - Write data on exception: `wb_reg`=30, `wb_data`=4 for mult or 5 for div; `pend_rd` is not written.
  - If `pend_rd`=0 and no exception, `wb_en` stays 0 and the state still returns to IDLE.
- **Stall (combinational, from registered state):** `issue_stall`=1 when either condition holds:
  - state≠IDLE and `issue_valid` and the DX instruction is `mult` or `div` (structural hazard);
  - state≠IDLE and `fd_rs_a` or `fd_rs_b` equals the effective destination (`pend_rd`; 30 once an exception has been captured) and that index is nonzero (RAW hazard).
- The op that was accepted in IDLE does not stall itself.

## Timing
- Reset value (reset=0 at an edge):
  - State is IDLE and the counter is 0.
  - `md_a`, `md_b`, `wb_data` and `wb_reg` are 0.
  - `md_ctrl_mult`, `md_ctrl_div`, `wb_en`, `issue_stall` and `busy` are 0.
- Reset mid-operation abandons the op with no write; any late `md_result_rdy` is ignored.
- Cycle timeline for an op accepted at edge N:
  - START during cycle N+1, with the start pulse high.
  - BUSY from edge N+2.
  - If `md_result_rdy` is high in cycle K, WB begins at edge K+1.
  - With the write port free, `wb_en` is high for one cycle, in cycle K+1.
  - State is IDLE at edge K+2.
- Minimum occupancy is 4 cycles.
- `md_a`/`md_b` are stable from START until the scheduler returns to IDLE.
- The RAW stall deasserts in the first IDLE cycle, i.e. after the register file has been written.
- Simultaneous events:
  - `md_result_rdy` on the same cycle as the TIMEOUT count: the result wins (no exception unless `md_exception` is high).
  - In IDLE, a new op is accepted in the same cycle the previous op's WB completes only if the state is already IDLE at that edge; there is no back-to-back WB→START.
- Counter is 8 bits, saturating.
- `wb_en` is never high while `pipe_wb_en` is high.

## Test plan
- **Mult commit:** `mult` r5=r1*r2 with A=6, B=7; `md_result_rdy` arrives 17 cycles after START -> one `md_ctrl_mult` pulse, then `wb_en`=1 with `wb_reg`=5 and `wb_data`=42; `busy` falls the next cycle.
- **Div by zero:** `div` r4 with B=0, `md_exception`=1 -> `wb_reg`=30, `wb_data`=5; r4 is never written.
- **Port conflict:** `pipe_wb_en` held high for 3 cycles while in WB -> `wb_en` stays 0 for those 3 cycles, then asserts in the 4th cycle with the same data.
- **Hazards:**
  - a second `mult` issued while BUSY -> `issue_stall`=1 until IDLE, then accepted;
  - `fd_rs_a`=5 while `pend_rd`=5 -> stall;
  - `fd_rs_a`=0 or 6 -> no stall.
- **Timeout and reset:**
  - with TIMEOUT=40 and no `md_result_rdy`, a `mult` -> WB at BUSY cycle 40 with `wb_reg`=30, `wb_data`=4;
  - reset=0 asserted mid-BUSY -> all outputs 0 at the next edge, no write, and a following `md_result_rdy` is ignored.
